// File: rtl/prog_mem_loader_pkg.sv
// prog_mem_loader_pkg: shared state encoding and pair geometry for the program memory loader
package prog_mem_loader_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_INST = 3'd1,
    LOAD_DATA = 3'd2,
    FLUSH     = 3'd3,
    DONE      = 3'd4,
    CSUM      = 3'd5
  } loader_state_t;
  localparam int PAIR_BYTES = 8;
endpackage

// File: rtl/prog_mem_loader_word_pair_packer.sv
// word_pair_packer: pairs accepted 32-bit words into 64-bit writes and tracks the pair index and byte address
module word_pair_packer
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              take_i,
  input  logic              last_i,
  input  logic [31:0]       word_i,
  output logic [31:0]       low_o,
  output logic              pair_done_o,
  output logic [ADDR_W-1:0] pair_idx_o,
  output logic [ADDR_W-1:0] addr_o
);
  logic [31:0]       low_q;
  logic              half_q;
  logic [ADDR_W-1:0] idx_q;
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      low_q  <= '0;
      half_q <= 1'b0;
      idx_q  <= '0;
    end else if (take_i) begin
      half_q <= ~half_q;
      if (!half_q) low_q <= word_i;
      else idx_q <= last_i ? '0 : idx_q + 1'b1;
    end
  end
  assign low_o       = low_q;
  assign pair_done_o = take_i && half_q;
  assign pair_idx_o  = idx_q;
  assign addr_o      = ADDR_W'(idx_q * PAIR_BYTES);
endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: streams word pairs into instruction then data memory and releases the core (optional LOADER_CHECKSUM_EN)
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int INST_PAIRS = 64,
  parameter int DATA_PAIRS = 64,
  parameter int FLUSH_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              enable_load_ex_mem,
  output logic              enable_halt,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [31:0]       InstExMemData1,
  output logic [31:0]       InstExMemData2,
  output logic [ADDR_W-1:0] DataExMemAddress,
  output logic [31:0]       DataExMemData1,
  output logic [31:0]       DataExMemData2,
  output logic              busy,
  output logic              load_done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum,
  output logic              csum_err
`endif
);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  loader_state_t     state_q, state_d;
  logic [FW-1:0]     flush_q;
  logic              loading, restart, take, last, pair_done;
  logic [31:0]       low_word;
  logic [ADDR_W-1:0] pair_idx, pair_addr;
  assign loading = state_q == LOAD_INST || state_q == LOAD_DATA;
  assign restart = start && (state_q == IDLE || state_q == DONE);
  assign take    = s_valid && loading;
  assign last    = state_q == LOAD_INST ? pair_idx == ADDR_W'(INST_PAIRS - 1)
                                        : pair_idx == ADDR_W'(DATA_PAIRS - 1);
  word_pair_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (restart),
    .take_i      (take),
    .last_i      (last),
    .word_i      (s_data),
    .low_o       (low_word),
    .pair_done_o (pair_done),
    .pair_idx_o  (pair_idx),
    .addr_o      (pair_addr)
  );
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        err_q;
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (take) sum_q <= sum_q + s_data;
      if (state_q == CSUM && s_valid && s_data != sum_q) err_q <= 1'b1;
    end
  end
  assign checksum = sum_q;
  assign csum_err = err_q;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = LOAD_INST;
      LOAD_INST:  if (pair_done && last) state_d = LOAD_DATA;
`ifdef LOADER_CHECKSUM_EN
      LOAD_DATA:  if (pair_done && last) state_d = CSUM;
      CSUM:       if (s_valid) state_d = s_data == sum_q ? FLUSH : IDLE;
`else
      LOAD_DATA:  if (pair_done && last) state_d = FLUSH;
`endif
      FLUSH:      if (flush_q == FW'(FLUSH_CYC - 1)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    s_ready            = loading || state_q == CSUM;
    enable_load_ex_mem = s_ready || state_q == FLUSH;
    enable_halt        = state_q == IDLE;
    busy               = enable_load_ex_mem;
    load_done          = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    flush_q <= reset || state_q != FLUSH ? '0 : flush_q + 1'b1;
    if (reset || restart) begin
      InstExMemAddress <= '0;
      InstExMemData1   <= '0;
      InstExMemData2   <= '0;
      DataExMemAddress <= '0;
      DataExMemData1   <= '0;
      DataExMemData2   <= '0;
    end else if (pair_done && state_q == LOAD_INST) begin
      InstExMemAddress <= pair_addr;
      InstExMemData1   <= low_word;
      InstExMemData2   <= s_data;
    end else if (pair_done) begin
      DataExMemAddress <= pair_addr;
      DataExMemData1   <= low_word;
      DataExMemData2   <= s_data;
    end
  end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: randomized self-checking bench comparing the loader against a word-count model
module tb_prog_mem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, enable_load_ex_mem, enable_halt, busy, load_done;
  logic [8:0]  InstExMemAddress, DataExMemAddress;
  logic [31:0] InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2;
  int          total = 0, bad = 0;
  logic [31:0] prev [6];
  prog_mem_loader #(.ADDR_W(9), .INST_PAIRS(2), .DATA_PAIRS(1), .FLUSH_CYC(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .s_valid            (s_valid),
    .s_data             (s_data),
    .s_ready            (s_ready),
    .enable_load_ex_mem (enable_load_ex_mem),
    .enable_halt        (enable_halt),
    .InstExMemAddress   (InstExMemAddress),
    .InstExMemData1     (InstExMemData1),
    .InstExMemData2     (InstExMemData2),
    .DataExMemAddress   (DataExMemAddress),
    .DataExMemData1     (DataExMemData1),
    .DataExMemData2     (DataExMemData2),
    .busy               (busy),
    .load_done          (load_done)
  );
  always #5 clk = ~clk;
  task automatic run_load(input logic [31:0] w [6], input int mode, input int poke);
    int n = 0, f = 0, cyc = 0, ip, dp;
    logic [8:0] ea, da;
    logic [31:0] e1, e2, d1, d2;
    logic v, act;
    start = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({InstExMemAddress, InstExMemData1, InstExMemData2} !== 73'd0) begin
      bad++;
      $display("FAIL start_clears_inst got=%h/%h/%h want=0/0/0", InstExMemAddress, InstExMemData1, InstExMemData2);
    end
    while (f < 3 && cyc < 80) begin
      v = n == 6 ? 1'($urandom_range(0, 1)) : mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      s_valid = v;
      s_data = n < 6 ? w[n] : $urandom;
      start = (cyc == poke);
      total++;
      if (s_ready !== (n < 6)) begin
        bad++;
        $display("FAIL s_ready cyc=%0d got=%b want=%b", cyc, s_ready, n < 6);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 6) f++;
      else if (v) n++;
      ip = (n < 4 ? n : 4) / 2;
      dp = (n > 4 ? n - 4 : 0) / 2;
      ea = ip > 0 ? 9'((ip - 1) * 8) : 9'd0;
      e1 = ip > 0 ? w[2 * ip - 2] : 32'd0;
      e2 = ip > 0 ? w[2 * ip - 1] : 32'd0;
      da = 9'd0;
      d1 = dp > 0 ? w[4] : 32'd0;
      d2 = dp > 0 ? w[5] : 32'd0;
      act = n < 6 || f < 2;
      total++;
      if ({InstExMemAddress, InstExMemData1, InstExMemData2} !== {ea, e1, e2}) begin
        bad++;
        $display("FAIL inst_port cyc=%0d got=%h/%h/%h want=%h/%h/%h", cyc, InstExMemAddress, InstExMemData1, InstExMemData2, ea, e1, e2);
      end
      total++;
      if ({DataExMemAddress, DataExMemData1, DataExMemData2} !== {da, d1, d2}) begin
        bad++;
        $display("FAIL data_port cyc=%0d got=%h/%h/%h want=%h/%h/%h", cyc, DataExMemAddress, DataExMemData1, DataExMemData2, da, d1, d2);
      end
      total++;
      if ({enable_load_ex_mem, enable_halt, busy, load_done} !== {act, 1'b0, act, ~act}) begin
        bad++;
        $display("FAIL status cyc=%0d got=%b want=%b", cyc, {enable_load_ex_mem, enable_halt, busy, load_done}, {act, 1'b0, act, ~act});
      end
      cyc++;
    end
    total++;
    if (f < 3) begin
      bad++;
      $display("FAIL load_timeout got=%0d words want=6", n);
    end
    s_valid = 1'b0;
    prev = w;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({enable_halt, enable_load_ex_mem, s_ready, busy, load_done} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=10000", {enable_halt, enable_load_ex_mem, s_ready, busy, load_done});
    end
    total++;
    if ({InstExMemAddress, InstExMemData1, InstExMemData2, DataExMemAddress, DataExMemData1, DataExMemData2} !== 146'd0) begin
      bad++;
      $display("FAIL reset_ports got=%h/%h/%h %h/%h/%h want=0", InstExMemAddress, InstExMemData1, InstExMemData2, DataExMemAddress, DataExMemData1, DataExMemData2);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] w [6];
    w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hA0, 32'hB0};
    run_load(w, 0, -1);
  endtask
  task automatic test_toggle_valid;
    logic [31:0] w [6];
    w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hA0, 32'hB0};
    run_load(w, 1, -1);
  endtask
  task automatic test_random_start_ignored;
    logic [31:0] w [6];
    for (int k = 0; k < 6; k++) w[k] = $urandom;
    run_load(w, 2, 3);
  endtask
  task automatic test_reset_mid_load;
    logic [31:0] w [6];
    for (int k = 0; k < 6; k++) w[k] = $urandom;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data = w[k];
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({enable_halt, enable_load_ex_mem, s_ready, busy, load_done} !== 5'b10000) begin
      bad++;
      $display("FAIL midreset_ctrl got=%b want=10000", {enable_halt, enable_load_ex_mem, s_ready, busy, load_done});
    end
    total++;
    if ({InstExMemAddress, InstExMemData1, InstExMemData2} !== 73'd0) begin
      bad++;
      $display("FAIL midreset_inst got=%h/%h/%h want=0/0/0", InstExMemAddress, InstExMemData1, InstExMemData2);
    end
    reset = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) w[k] = $urandom;
    run_load(w, 2, -1);
  endtask
  task automatic test_reload;
    logic [31:0] w [6];
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({load_done, enable_halt, InstExMemAddress, InstExMemData1, InstExMemData2} !== {2'b10, 9'd8, prev[2], prev[3]}) begin
      bad++;
      $display("FAIL done_hold got=%b%b %h/%h/%h want=10 008/%h/%h", load_done, enable_halt, InstExMemAddress, InstExMemData1, InstExMemData2, prev[2], prev[3]);
    end
    w = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA};
    run_load(w, 0, -1);
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_toggle_valid;
    test_random_start_ignored;
    test_reset_mid_load;
    test_reload;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
